// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the PWM generator.
// Used by pwm_prescaler and pwm_gen.
package pwm_pkg;

    localparam int PWM_WIDTH_DEF    = 8;
    localparam int PWM_PRESCALE_DEF = 1;

    // System clocks in one full PWM period.
    function automatic int unsigned pwm_period(
        input int unsigned width,
        input int unsigned prescale
    );
        return prescale * (32'd1 << width);
    endfunction

    // Prescaler counter width; never below one bit.
    function automatic int unsigned pwm_pre_width(
        input int unsigned prescale
    );
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable generator: one tick every PRESCALE system clocks.
// PRESCALE=1 ticks on every cycle.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE = PWM_PRESCALE_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    output logic tick
);

    localparam int PW = pwm_pre_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick = (pre_q == LAST);

    always_comb begin
        pre_d = pre_q + 1'b1;
        if (tick) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// Single-channel PWM: free-running counter compared against duty.
// Define PWM_DUTY_SHADOW_EN to latch duty only at period start.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH_DEF,
    parameter int PRESCALE = PWM_PRESCALE_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] duty,
    output logic             pwmOut
);

    logic             tick;
    logic             wrap;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] duty_eff;
    logic             pwm_q;
    logic             pwm_d;

    pwm_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_pre (
        .CLK  (CLK),
        .RST_N(RST_N),
        .tick (tick)
    );

    assign wrap = tick && (cnt_q == {WIDTH{1'b1}});

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;

    // Reload only as the counter rolls to 0 so each period is one clean pulse.
    always_comb begin
        shadow_d = shadow_q;
        if (wrap) begin
            shadow_d = duty;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign duty_eff = shadow_q;
`else
    logic unused_wrap;

    assign unused_wrap = wrap;
    assign duty_eff    = duty;
`endif

    assign pwm_d = (cnt_q < duty_eff);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwmOut = pwm_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: duty table, prescaler, reset and
// duty-change corner cases (both PWM_DUTY_SHADOW_EN builds).
module tb_pwm_gen;
    import pwm_pkg::*;

    logic       CLK;
    logic       RST_N;
    logic [7:0] duty;
    logic       pwm1;
    logic       pwm4;

    int total = 0;
    int bad   = 0;

    pwm_gen #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .duty  (duty),
        .pwmOut(pwm1)
    );

    pwm_gen #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .duty  (duty),
        .pwmOut(pwm4)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    typedef struct {
        bit         p4;
        logic [7:0] d;
        int         cycles;
        int         exp_hi;
        int         exp_rise;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic [7:0] d);
        RST_N = 1'b0;
        duty  = d;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic run_window(input bit p4, input int n,
                              output int hi, output int rise);
        logic prev;
        logic cur;
        prev = 1'b0;
        hi   = 0;
        rise = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            cur = p4 ? pwm4 : pwm1;
            if (cur) hi++;
            if (cur && !prev) rise++;
            prev = cur;
        end
    endtask

    vec_t vecs[7];

    initial begin
        int hi;
        int rise;
        int h1;
        int h2;
        int h3;
        logic s100;
        logic s101;

`ifdef PWM_DUTY_SHADOW_EN
        // Shadow starts at 0: first period after reset is flat.
        vecs[0] = '{1'b0, 8'd0,   768,  0,   0};
        vecs[1] = '{1'b0, 8'd255, 768,  510, 2};
        vecs[2] = '{1'b0, 8'd180, 768,  360, 2};
        vecs[3] = '{1'b0, 8'd128, 512,  128, 1};
        vecs[4] = '{1'b0, 8'd1,   512,  1,   1};
        vecs[5] = '{1'b1, 8'd64,  3072, 512, 2};
        vecs[6] = '{1'b0, 8'd200, 256,  0,   0};
`else
        vecs[0] = '{1'b0, 8'd0,   768,  0,   0};
        vecs[1] = '{1'b0, 8'd255, 768,  765, 3};
        vecs[2] = '{1'b0, 8'd180, 512,  360, 2};
        vecs[3] = '{1'b0, 8'd128, 256,  128, 1};
        vecs[4] = '{1'b0, 8'd1,   256,  1,   1};
        vecs[5] = '{1'b1, 8'd64,  2048, 512, 2};
        vecs[6] = '{1'b0, 8'd200, 256,  200, 1};
`endif

        RST_N = 1'b1;
        duty  = 8'd200;
        #3;

        // Async reset with duty=200 held low for several cycles.
        RST_N = 1'b0;
        #1;
        check("rst_async_pwm1", int'(pwm1), 0);
        check("rst_async_pwm4", int'(pwm4), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            check("rst_hold_pwm1", int'(pwm1), 0);
        end
        @(negedge CLK);
        RST_N = 1'b1;

        check("period_fn_p1", int'(pwm_period(8, 1)), 256);
        check("period_fn_p4", int'(pwm_period(8, 4)), 1024);

        for (int i = 0; i < 7; i++) begin
            do_reset(vecs[i].d);
            run_window(vecs[i].p4, vecs[i].cycles, hi, rise);
            check($sformatf("vec%0d_high d=%0d", i, vecs[i].d),
                  hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_rises d=%0d", i, vecs[i].d),
                  rise, vecs[i].exp_rise);
        end

        // Mid-period duty change 180 -> 50 at cnt=100 of period 2.
        do_reset(8'd180);
        h1 = 0;
        h2 = 0;
        h3 = 0;
        s100 = 1'b0;
        s101 = 1'b0;
        for (int k = 1; k <= 768; k++) begin
            @(posedge CLK);
            #1;
            if (k <= 256) h1 += int'(pwm1);
            else if (k <= 512) h2 += int'(pwm1);
            else h3 += int'(pwm1);
            if (k == 356) begin
                s100 = pwm1;
                duty = 8'd50;
            end
            if (k == 357) s101 = pwm1;
        end
`ifdef PWM_DUTY_SHADOW_EN
        check("chg_p1_high", h1, 0);
        check("chg_p2_high", h2, 180);
        check("chg_after", int'(s101), 1);
`else
        check("chg_p1_high", h1, 180);
        check("chg_p2_high", h2, 100);
        check("chg_after", int'(s101), 0);
`endif
        check("chg_before", int'(s100), 1);
        check("chg_p3_high", h3, 50);

        // Reset at cnt=90 mid-pulse, then a fresh period from cnt=0.
        do_reset(8'd180);
        repeat (90) @(posedge CLK);
        #5;
`ifndef PWM_DUTY_SHADOW_EN
        check("rst90_before", int'(pwm1), 1);
`endif
        RST_N = 1'b0;
        #1;
        check("rst90_now", int'(pwm1), 0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst90_hold", int'(pwm1), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_window(1'b0, 256, hi, rise);
`ifdef PWM_DUTY_SHADOW_EN
        check("rst90_p1_high", hi, 0);
        run_window(1'b0, 256, hi, rise);
`endif
        check("rst90_high", hi, 180);
        check("rst90_rises", rise, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
